// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: state encoding,
// default data width and the drain-timeout derivation.
package uart_pkg;

  localparam int DATAWIDTH_DEF = 8;
  localparam int OVERSAMPLE    = 16;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Ticks needed to finish a worst-case frame: start + data + parity + stop + slack.
  function automatic int stop_tmo_f(input int dw);
    return OVERSAMPLE * (dw + 4);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers and an occupancy output.
// Head is presented combinationally; output reads zero while empty.
module uart_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  // A write into a full FIFO is legal when the head is popped in the same cycle.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || rd_en_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver controller: oversampling tick, enable gating with clean
// drain on disable, received-byte FIFO and host-side error status.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATAWIDTH  = DATAWIDTH_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int STOP_TMO   = stop_tmo_f(DATAWIDTH)
) (
  input  logic                          clk,
  input  logic                          rx_rst,
  input  logic                          cfg_en,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic                          clr,
  output logic                          s_tick,
  output logic                          rx_en,
  input  logic [DATAWIDTH-1:0]          rx_dout,
  input  logic                          rx_done,
  input  logic                          rx_busy,
  input  logic                          rx_error,
  input  logic                          rd_en,
  output logic [DATAWIDTH-1:0]          rd_data,
  output logic                          rd_err,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overrun,
  output logic [7:0]                    err_cnt,
  output logic                          active
);

  localparam int TW = $clog2(STOP_TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(STOP_TMO - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             rx_en_q;
  logic             overrun_q, overrun_d;
  logic [7:0]       err_cnt_q, err_cnt_d, err_base;
  logic             fifo_wr, drop;
  logic [DATAWIDTH:0] head;

  assign s_tick = (state_q != ST_OFF) && (cnt_q == div_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF:   if (cfg_en) state_d = ST_RUN;
      ST_RUN:   if (!cfg_en) state_d = rx_busy ? ST_DRAIN : ST_OFF;
      ST_DRAIN: if (!rx_busy || rx_done || (s_tick && tmo_q == TMO_LAST))
                  state_d = ST_OFF;
      default:  state_d = ST_OFF;
    endcase
  end

  // Divisor is sampled only on OFF->RUN so a live frame never sees a rate change.
  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    if (state_q == ST_OFF && cfg_en) div_d = cfg_div;
    if (state_q == ST_OFF || state_d == ST_OFF) cnt_d = '0;
    else if (s_tick)                            cnt_d = '0;
    else                                        cnt_d = cnt_q + 1'b1;
    if (state_q == ST_RUN && state_d == ST_DRAIN) tmo_d = '0;
    else if (state_q == ST_DRAIN && s_tick)       tmo_d = tmo_q + 1'b1;
  end

  assign fifo_wr = rx_done && (!full || rd_en);
  assign drop    = rx_done && !fifo_wr;

  // Clear acts first so an event in the same cycle lands on the cleared value.
  always_comb begin
    overrun_d = (overrun_q && !clr) || drop;
    err_base  = clr ? 8'd0 : err_cnt_q;
    err_cnt_d = err_base;
    if (rx_done && rx_error && err_base != 8'hFF) err_cnt_d = err_base + 8'd1;
  end

  always_ff @(posedge clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_q   <= ST_OFF;
      div_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      rx_en_q   <= 1'b0;
      overrun_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      rx_en_q   <= (state_d != ST_OFF);
      overrun_q <= overrun_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rx_en   = rx_en_q;
  assign active  = rx_en_q;
  assign overrun = overrun_q;
  assign err_cnt = err_cnt_q;

  uart_sync_fifo #(
    .WIDTH (DATAWIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rx_rst),
    .wr_en_i   (fifo_wr),
    .wr_data_i ({rx_error, rx_dout}),
    .rd_en_i   (rd_en),
    .rd_data_o (head),
    .empty_o   (empty),
    .full_o    (full),
    .level_o   (level)
  );

  assign rd_err  = head[DATAWIDTH];
  assign rd_data = head[DATAWIDTH-1:0];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomised bench for uart_rx_ctrl against a cycle-level behavioural model
// with a queue scoreboard for FIFO contents.
module tb_uart_rx_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int DIVW  = 16;
  localparam int STOP  = 192;

  logic            clk = 1'b0;
  logic            rx_rst = 1'b1;
  logic            cfg_en = 1'b0, clr = 1'b0;
  logic [DIVW-1:0] cfg_div = '0;
  logic            rx_done = 1'b0, rx_busy = 1'b0, rx_error = 1'b0, rd_en = 1'b0;
  logic [DW-1:0]   rx_dout = '0;
  logic            s_tick, rx_en, rd_err, empty, full, overrun, active;
  logic [DW-1:0]   rd_data;
  logic [3:0]      level;
  logic [7:0]      err_cnt;

  uart_rx_ctrl #(
    .DATAWIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_W(DIVW), .STOP_TMO(STOP)
  ) dut (
    .clk(clk), .rx_rst(rx_rst), .cfg_en(cfg_en), .cfg_div(cfg_div), .clr(clr),
    .s_tick(s_tick), .rx_en(rx_en), .rx_dout(rx_dout), .rx_done(rx_done),
    .rx_busy(rx_busy), .rx_error(rx_error), .rd_en(rd_en), .rd_data(rd_data),
    .rd_err(rd_err), .empty(empty), .full(full), .level(level),
    .overrun(overrun), .err_cnt(err_cnt), .active(active)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: mode 0=off 1=running 2=draining; ticks derived from cycles since start.
  int            m_mode = 0, m_div = 0, m_since = 0, m_dticks = 0, m_errc = 0;
  bit            m_ov = 0;
  logic [DW:0]   sb_q[$];

  always @(negedge clk) begin
    bit tick, wr_ok;
    int base;
    if (rx_rst) begin
      m_mode = 0; m_div = 0; m_since = 0; m_dticks = 0; m_errc = 0; m_ov = 0;
      sb_q.delete();
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_err", rd_err, 0);
    end
    tick = (m_mode != 0) && (((m_since + 1) % (m_div + 1)) == 0);
    chk("rx_en", rx_en, m_mode != 0);
    chk("active", active, m_mode != 0);
    chk("s_tick", s_tick, tick);
    chk("empty", empty, sb_q.size() == 0);
    chk("full", full, sb_q.size() == DEPTH);
    chk("level", level, sb_q.size());
    if (sb_q.size() > 0) begin
      chk("rd_data", rd_data, sb_q[0][DW-1:0]);
      chk("rd_err", rd_err, sb_q[0][DW]);
    end
    chk("overrun", overrun, m_ov);
    chk("err_cnt", err_cnt, m_errc);
    if (!rx_rst) begin
      wr_ok = rx_done && (sb_q.size() < DEPTH || rd_en);
      if (rd_en && sb_q.size() > 0) void'(sb_q.pop_front());
      if (wr_ok) sb_q.push_back({rx_error, rx_dout});
      m_ov = (m_ov && !clr) || (rx_done && !wr_ok);
      base = clr ? 0 : m_errc;
      if (rx_done && rx_error && base < 255) base++;
      m_errc = base;
      case (m_mode)
        0: if (cfg_en) begin m_mode = 1; m_div = int'(cfg_div); m_since = 0; end
        1: begin
          m_since++;
          if (!cfg_en) begin
            if (rx_busy) begin m_mode = 2; m_dticks = 0; end
            else m_mode = 0;
          end
        end
        default: begin
          m_since++;
          if (tick) m_dticks++;
          if (!rx_busy || rx_done || m_dticks == STOP) m_mode = 0;
        end
      endcase
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
      rx_done = 1'b0; rd_en = 1'b0; clr = 1'b0;
    end
  endtask

  task automatic frame(input logic [DW-1:0] d, input logic e);
    rx_done = 1'b1; rx_dout = d; rx_error = e;
    step();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
  endtask

  initial begin
    step(3); rx_rst = 1'b0; step(2);
    // tick period and divisor lock
    cfg_div = 16'd3; cfg_en = 1'b1; step(20);
    cfg_div = 16'd9; step(12);
    // ordered capture with error flags
    frame(8'hA5, 1'b0); frame(8'h3C, 1'b1); frame(8'hFF, 1'b0);
    step(2); repeat (3) pop(); step(2);
    // overflow, then read+write while full
    repeat (9) frame(8'($urandom), 1'($urandom_range(0, 1)));
    step();
    rx_done = 1'b1; rx_dout = 8'h77; rx_error = 1'b0; rd_en = 1'b1; step();
    step(); repeat (9) pop();
    // drain finished by a frame
    rx_busy = 1'b1; step(3); cfg_en = 1'b0; step(10);
    frame(8'h5A, 1'b0); rx_busy = 1'b0; step(5); pop();
    // drain forced off by timeout
    cfg_div = 16'd0; cfg_en = 1'b1; step(3); rx_busy = 1'b1; step();
    cfg_en = 1'b0; step(200); rx_busy = 1'b0; step(3);
    // reset while draining with data queued
    repeat (5) frame(8'($urandom), 1'b1);
    cfg_div = 16'd2; cfg_en = 1'b1; step(3); rx_busy = 1'b1; cfg_en = 1'b0; step(5);
    rx_rst = 1'b1; step(2); rx_rst = 1'b0; rx_busy = 1'b0; step(2);
    // error counter saturation and clear
    repeat (260) frame(8'($urandom), 1'b1);
    step(2);
    rx_done = 1'b1; rx_error = 1'b1; clr = 1'b1; step(); step();
    clr = 1'b1; step(); step();
    repeat (9) pop();
    // random traffic
    repeat (3000) begin
      if ($urandom_range(0, 49) == 0) cfg_en = ~cfg_en;
      if ($urandom_range(0, 99) == 0) cfg_div = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0)  rx_busy = ~rx_busy;
      rx_done  = ($urandom_range(0, 3) == 0);
      rx_dout  = 8'($urandom);
      rx_error = ($urandom_range(0, 3) == 0);
      rd_en    = ($urandom_range(0, 2) == 0);
      clr      = ($urandom_range(0, 63) == 0);
      @(posedge clk); #1;
    end
    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
